// File: rtl/lane_deskew.sv
// Two-lane deskew: locates a marker byte on each lane, measures the inter-lane
// skew and delays the leading lane so that both lanes leave byte-aligned.
module lane_deskew #(
  parameter int         MAX_SKEW = 7,
  parameter logic [7:0] MARKER   = 8'hF2,
  parameter int         SKW      = $clog2(MAX_SKEW + 1)
) (
  input  logic           enc_clk,
  input  logic           rst,
  input  logic           enable_deskew,
  input  logic [7:0]     lane_0_rx,
  input  logic [7:0]     lane_1_rx,
  input  logic           data_os,
  output logic [7:0]     lane_0_aligned,
  output logic [7:0]     lane_1_aligned,
  output logic           data_os_aligned,
  output logic           deskew_done,
  output logic           lead_lane,
  output logic [SKW-1:0] skew_value,
  output logic           skew_error
);

  typedef enum logic [1:0] {IDLE, SEARCH, WAIT_LAG, ALIGNED} state_t;

  state_t         state, state_nxt;
  logic [SKW-1:0] count, count_nxt, skew_nxt;
  logic           lead_nxt, err_nxt;

  // Index n holds the input from n cycles ago; lane 0 carries {data_os, byte}.
  logic [8:0]     hist0 [1:MAX_SKEW];
  logic [7:0]     hist1 [1:MAX_SKEW];
  logic [8:0]     tap0_sel;
  logic [7:0]     tap1_sel;

  logic match0, match1, lag_match;

  assign match0      = (lane_0_rx == MARKER);
  assign match1      = (lane_1_rx == MARKER);
  assign lag_match   = lead_lane ? match0 : match1;
  assign deskew_done = (state == ALIGNED);

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= MAX_SKEW; i++) begin
        hist0[i] <= '0;
        hist1[i] <= '0;
      end
    end else begin
      hist0[1] <= {data_os, lane_0_rx};
      hist1[1] <= lane_1_rx;
      for (int unsigned i = 2; i <= MAX_SKEW; i++) begin
        hist0[i] <= hist0[i-1];
        hist1[i] <= hist1[i-1];
      end
    end
  end

  always_comb begin
    tap0_sel = {data_os, lane_0_rx};
    tap1_sel = lane_1_rx;
    for (int unsigned i = 1; i <= MAX_SKEW; i++) begin
      if (skew_value == SKW'(i)) begin
        tap0_sel = hist0[i];
        tap1_sel = hist1[i];
      end
    end
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A dropped enable overrides every other transition, including the error.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    skew_nxt  = skew_value;
    lead_nxt  = lead_lane;
    err_nxt   = 1'b0;
    if (!enable_deskew) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SEARCH;
          count_nxt = '0;
        end
        SEARCH: begin
          if (match0 && match1) begin
            skew_nxt  = '0;
            lead_nxt  = 1'b0;
            state_nxt = ALIGNED;
          end else if (match0 || match1) begin
            lead_nxt  = match1;
            count_nxt = SKW'(1);
            state_nxt = WAIT_LAG;
          end
        end
        WAIT_LAG: begin
          if (lag_match) begin
            skew_nxt  = count;
            state_nxt = ALIGNED;
          end else if (count == SKW'(MAX_SKEW)) begin
            count_nxt = '0;
            err_nxt   = 1'b1;
            state_nxt = SEARCH;
          end else begin
            count_nxt = count + SKW'(1);
          end
        end
        ALIGNED: state_nxt = ALIGNED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      skew_value <= '0;
      lead_lane  <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      count      <= count_nxt;
      skew_value <= skew_nxt;
      lead_lane  <= lead_nxt;
      skew_error <= err_nxt;
    end
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      lane_0_aligned  <= '0;
      lane_1_aligned  <= '0;
      data_os_aligned <= 1'b0;
    end else if (state == ALIGNED && enable_deskew) begin
      if (lead_lane) begin
        lane_0_aligned  <= lane_0_rx;
        data_os_aligned <= data_os;
        lane_1_aligned  <= tap1_sel;
      end else begin
        {data_os_aligned, lane_0_aligned} <= tap0_sel;
        lane_1_aligned                    <= lane_1_rx;
      end
    end else begin
      lane_0_aligned  <= '0;
      lane_1_aligned  <= '0;
      data_os_aligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_deskew.sv
// Self-checking bench for lane_deskew: random lane data with placed markers,
// expected outputs derived from the marker timeline of each scenario.
module tb_lane_deskew;

  localparam int         MAX_SKEW = 7;
  localparam logic [7:0] MARKER   = 8'hF2;
  localparam int         NONE     = 100000;

  logic       enc_clk;
  logic       rst;
  logic       enable_deskew;
  logic [7:0] lane_0_rx, lane_1_rx;
  logic       data_os;
  logic [7:0] lane_0_aligned, lane_1_aligned;
  logic       data_os_aligned, deskew_done, lead_lane, skew_error;
  logic [2:0] skew_value;

  int tests = 0;
  int fails = 0;

  logic [7:0] b0 [0:255];
  logic [7:0] b1 [0:255];
  logic       d0 [0:255];
  logic       en_a [0:255];

  lane_deskew #(.MAX_SKEW(MAX_SKEW), .MARKER(MARKER)) dut (
    .enc_clk(enc_clk), .rst(rst), .enable_deskew(enable_deskew),
    .lane_0_rx(lane_0_rx), .lane_1_rx(lane_1_rx), .data_os(data_os),
    .lane_0_aligned(lane_0_aligned), .lane_1_aligned(lane_1_aligned),
    .data_os_aligned(data_os_aligned), .deskew_done(deskew_done),
    .lead_lane(lead_lane), .skew_value(skew_value), .skew_error(skew_error)
  );

  initial enc_clk = 1'b0;
  always #5 enc_clk = ~enc_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  function automatic logic [7:0] rand_byte(input bit allow_marker);
    logic [7:0] x;
    x = 8'($urandom_range(0, 255));
    if (!allow_marker && x == MARKER) x = x ^ 8'h01;
    return x;
  endfunction

  // Scenario: t_al/k/ld describe the marker pair that should align (t_al<0: none),
  // solo_t/solo_l a lead marker with no partner, drop the cycle enable goes low.
  task automatic run(input string name, input int n, input bit do_reset,
                     input int t_al, input int k, input bit ld,
                     input int solo_t, input bit solo_l, input int drop,
                     input int pk, input bit pl);
    int err_c, first_m;
    bit al;
    logic [7:0] e_l0, e_l1;
    logic e_dos, e_done, e_err, e_lead;
    logic [2:0] e_skew;
    al = (t_al >= 0);
    for (int c = 0; c < n; c++) begin
      bit free;
      free = al && (c > t_al + k);
      b0[c] = rand_byte(free);
      b1[c] = rand_byte(free);
      d0[c] = 1'($urandom_range(0, 1));
      en_a[c] = (c < drop);
    end
    if (solo_t >= 0) begin
      if (solo_l) b1[solo_t] = MARKER; else b0[solo_t] = MARKER;
    end
    if (al) begin
      if (ld) begin b1[t_al] = MARKER; b0[t_al + k] = MARKER; end
      else    begin b0[t_al] = MARKER; b1[t_al + k] = MARKER; end
    end
    err_c   = (solo_t >= 0) ? solo_t + MAX_SKEW + 1 : -1;
    first_m = (solo_t >= 0) ? solo_t : (al ? t_al : n);

    if (do_reset) begin
      rst = 1'b1; enable_deskew = 1'b0;
      @(negedge enc_clk); @(negedge enc_clk);
      rst = 1'b0;
    end

    for (int c = 0; c < n; c++) begin
      e_done = al && c >= t_al + k + 1 && c <= drop;
      e_l0 = '0; e_l1 = '0; e_dos = 1'b0;
      if (al && c >= t_al + k + 2 && c <= drop) begin
        if (!ld) begin
          e_l0 = b0[c-1-k]; e_dos = d0[c-1-k]; e_l1 = b1[c-1];
        end else begin
          e_l0 = b0[c-1]; e_dos = d0[c-1]; e_l1 = b1[c-1-k];
        end
      end
      e_skew = (al && c >= t_al + k + 1) ? 3'(k) : 3'(pk);
      e_err  = (c == err_c);

      tests++;
      if (lane_0_aligned !== e_l0) begin
        fails++;
        $display("FAIL %s lane_0_aligned cyc %0d got %h exp %h", name, c, lane_0_aligned, e_l0);
      end
      tests++;
      if (lane_1_aligned !== e_l1) begin
        fails++;
        $display("FAIL %s lane_1_aligned cyc %0d got %h exp %h", name, c, lane_1_aligned, e_l1);
      end
      tests++;
      if (data_os_aligned !== e_dos) begin
        fails++;
        $display("FAIL %s data_os_aligned cyc %0d got %b exp %b", name, c, data_os_aligned, e_dos);
      end
      tests++;
      if (deskew_done !== e_done) begin
        fails++;
        $display("FAIL %s deskew_done cyc %0d got %b exp %b", name, c, deskew_done, e_done);
      end
      tests++;
      if (skew_value !== e_skew) begin
        fails++;
        $display("FAIL %s skew_value cyc %0d got %0d exp %0d", name, c, skew_value, e_skew);
      end
      tests++;
      if (skew_error !== e_err) begin
        fails++;
        $display("FAIL %s skew_error cyc %0d got %b exp %b", name, c, skew_error, e_err);
      end
      if (c <= first_m || (al && c >= t_al + k + 1)) begin
        e_lead = (c <= first_m) ? pl : ld;
        tests++;
        if (lead_lane !== e_lead) begin
          fails++;
          $display("FAIL %s lead_lane cyc %0d got %b exp %b", name, c, lead_lane, e_lead);
        end
      end

      lane_0_rx = b0[c];
      lane_1_rx = b1[c];
      data_os   = d0[c];
      enable_deskew = en_a[c];
      @(negedge enc_clk);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if (lane_0_aligned !== 8'h00 || lane_1_aligned !== 8'h00 || data_os_aligned !== 1'b0) begin
      fails++;
      $display("FAIL %s data outputs got %h/%h/%b exp 00/00/0", name, lane_0_aligned, lane_1_aligned, data_os_aligned);
    end
    tests++;
    if (deskew_done !== 1'b0 || skew_error !== 1'b0) begin
      fails++;
      $display("FAIL %s done/err got %b/%b exp 0/0", name, deskew_done, skew_error);
    end
    tests++;
    if (lead_lane !== 1'b0 || skew_value !== 3'd0) begin
      fails++;
      $display("FAIL %s lead/skew got %b/%0d exp 0/0", name, lead_lane, skew_value);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_deskew = 1'b1;
    lane_0_rx = MARKER; lane_1_rx = MARKER; data_os = 1'b1;
    @(negedge enc_clk); @(negedge enc_clk);
    check_all_zero("reset");
  endtask

  task automatic test_zero_skew();
    run("zero_skew", 30, 1'b1, 10, 0, 1'b0, -1, 1'b0, NONE, 0, 1'b0);
  endtask

  task automatic test_lane0_leads();
    run("lane0_lead3", 35, 1'b1, 10, 3, 1'b0, -1, 1'b0, NONE, 0, 1'b0);
  endtask

  task automatic test_lane1_leads_max();
    run("lane1_leadmax", 40, 1'b1, 10, MAX_SKEW, 1'b1, -1, 1'b0, NONE, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run("overflow", 45, 1'b1, 25, 2, 1'b0, 10, 1'b0, NONE, 0, 1'b0);
  endtask

  task automatic test_enable_drop();
    run("enable_drop", 34, 1'b1, 10, 4, 1'b1, -1, 1'b0, 30, 0, 1'b0);
    run("reenable", 30, 1'b0, 10, 2, 1'b0, -1, 1'b0, NONE, 4, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int k, t;
      bit ld;
      k  = $urandom_range(0, MAX_SKEW);
      ld = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      t  = $urandom_range(3, 15);
      run("random", t + k + 20, 1'b1, t, k, ld, -1, 1'b0, NONE, 0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    run("pre_async", 13, 1'b1, -1, 0, 1'b0, 10, 1'b1, NONE, 0, 1'b0);
    #2;
    tests++;
    if (lead_lane !== 1'b1) begin
      fails++;
      $display("FAIL async_pre lead_lane got %b exp 1", lead_lane);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    run("post_async", 35, 1'b1, 10, 5, 1'b1, -1, 1'b0, NONE, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    enable_deskew = 1'b0;
    lane_0_rx = '0; lane_1_rx = '0; data_os = 1'b0;
    test_reset();
    test_zero_skew();
    test_lane0_leads();
    test_lane1_leads_max();
    test_overflow();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_deskew.md
# lane_deskew

Aligns the two receive lanes after decoding. It sits directly downstream of the decoding stage and consumes its per-lane byte streams plus its `enable_deskew` and `data_os` outputs. It measures the inter-lane skew by locating a marker byte on each lane, then delays the leading lane by the measured number of cycles. It delivers byte-aligned lane pairs and a matching `data_os` flag to the lane-bonding logic.

## Interface
- `MAX_SKEW`, default 7: largest correctable skew in `enc_clk` cycles (1..15).
- `MARKER`, default 8'hF2: byte value marking the alignment point on each lane.
- `SKW`, default $clog2(MAX_SKEW+1): width of `skew_value`, derived from `MAX_SKEW`.
- `enc_clk`  in  1  the only clock.
- `rst`  in  1  reset, asynchronous, active-high. Clears all state.
- `enable_deskew`  in  1  level; high requests search and alignment, low forces IDLE.
- `lane_0_rx`  in  8  decoded byte of lane 0, one per cycle.
- `lane_1_rx`  in  8  decoded byte of lane 1, one per cycle.
- `data_os`  in  1  data/ordered-set flag, associated with lane 0.
- `lane_0_aligned`  out  8  deskewed lane 0 byte.
- `lane_1_aligned`  out  8  deskewed lane 1 byte.
- `data_os_aligned`  out  1  `data_os` delayed with lane 0.
- `deskew_done`  out  1  high while in ALIGNED.
- `lead_lane`  out  1  lane that is ahead: 0 = lane 0, 1 = lane 1. Value is 0 when skew is 0.
- `skew_value`  out  SKW  measured skew in cycles.
- `skew_error`  out  1  one-cycle pulse when the skew exceeds `MAX_SKEW`.

## Operation
- **History.** Per-lane shift registers of `MAX_SKEW` entries shift every cycle in all states. Lane 0's history carries `{data_os, byte}`.
  - Tap 0 is the current input (combinational).
  - Tap n is the input from n cycles earlier.
- **States:** IDLE, SEARCH, WAIT_LAG, ALIGNED. Encoding is free.
- **IDLE**
  - `enable_deskew` = 1 → SEARCH.
- **SEARCH.** Compare both lane inputs against `MARKER` each cycle.
  - Both match in the same cycle → latch `skew_value` = 0 and `lead_lane` = 0, go to ALIGNED.
  - Only lane L matches → latch `lead_lane` = L, set count = 1, go to WAIT_LAG.
- **WAIT_LAG.** Watch only the lagging lane.
  - Lagging lane matches → latch `skew_value` = count, go to ALIGNED.
  - Else if count == `MAX_SKEW` → go to SEARCH and assert `skew_error` for one cycle.
  - Else count += 1.
  - Further markers on the leading lane are ignored.
- **ALIGNED.** Each edge registers:
  - leading lane output ← its tap `skew_value`;
  - lagging lane output ← its tap 0;
  - `data_os_aligned` ← lane 0's tap (the same tap as lane 0's byte).
  - Skew is frozen. Later marker bytes are forwarded as ordinary data and are not re-measured.
- **`enable_deskew` = 0 in any state** → IDLE on the next edge.
  - Clears `deskew_done`, the data outputs, and the counter.
  - `skew_value` and `lead_lane` hold their last values.
- **Outputs outside ALIGNED:** `lane_0_aligned`, `lane_1_aligned` and `data_os_aligned` are driven to 0 on each edge.
- **Count width:** `SKW` bits. Count never exceeds `MAX_SKEW`, so it cannot wrap.

## Timing
- **Reset values:** all outputs 0, state IDLE, count 0, history registers 0.
- **`rst` mid-operation:** immediate return to the reset values, independent of the clock.
- **Marker timeline.** Leading marker sampled in cycle T, lagging marker in cycle T+k:
  - state = ALIGNED from cycle T+k+1;
  - `deskew_done` = 1 from cycle T+k+1;
  - `skew_value` = k and `lead_lane` valid from cycle T+k+1.
- **First aligned output.** Visible in cycle T+k+2. It is the pair following the markers: lead byte from T+1, lag byte from T+k+1. Marker bytes themselves are not output.
- **Latency in ALIGNED:** lagging lane 1 cycle; leading lane `skew_value`+1 cycles.
- **Error pulse.** With no lagging marker, the last sample is taken in cycle T+`MAX_SKEW`. `skew_error` = 1 during cycle T+`MAX_SKEW`+1 only, with state = SEARCH in that cycle.
- **Simultaneous events:**
  - `enable_deskew` falling takes priority over marker detection and over the error.
  - In SEARCH, a match on both lanes takes priority over a single-lane match.
- **`enable_deskew` re-asserted after IDLE:** the full search restarts. The previous skew is not reused.

## Test plan
- **Zero skew.** Lanes carry an incrementing byte pattern; `MARKER` on both lanes in cycle 10. Required: `skew_value` = 0, `deskew_done` = 1 from cycle 11, from cycle 12 on `lane_0_aligned` == `lane_1_aligned` == input delayed 1.
- **Lane 0 leads by 3.** Lane 0 marker in cycle 10, lane 1 marker in cycle 13. Required: `lead_lane` = 0, `skew_value` = 3, `deskew_done` from cycle 14, lane 0 delayed 4 cycles, lane 1 delayed 1, output pairs equal every cycle. `data_os` toggled on lane 0 must track lane 0's bytes.
- **Lane 1 leads by `MAX_SKEW`.** Lane 1 marker in cycle 10, lane 0 marker in cycle 17. Required: `lead_lane` = 1, `skew_value` = 7, aligned pairs equal from cycle 19.
- **Skew overflow.** Lane 0 marker in cycle 10, no lane 1 marker until cycle 20. Required: `skew_error` pulses in cycle 18 only, state returns to SEARCH, `deskew_done` stays 0. A fresh marker pair at skew 2 afterwards must align with `skew_value` = 2.
- **Enable drop.** Drop `enable_deskew` in cycle 30 during ALIGNED. Required: from cycle 31, `deskew_done` = 0 and data outputs = 0; re-enabling restarts the search.
- **Asynchronous reset.** Assert `rst` mid-cycle during WAIT_LAG. Required: all outputs are 0 immediately; after release, a normal alignment completes with the expected values.
